mem_responder: RTL
==================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter: DEPTH, 64, number of 32-bit words held; power of two, 4..256.
REQ-002 Parameter: LATENCY, 2, wait cycles between request acceptance and response; 1..15.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: req  input  1  single-cycle request pulse from the multicycle core.
REQ-006 Port: we  input  1  1 = store, 0 = load; sampled with req.
REQ-007 Port: addr  input  32  byte address (instruction or data, per core IorD select); sampled with req.
REQ-008 Port: wdata  input  32  store data; sampled with req.
REQ-009 Port: busy  output  1  high while a request is in progress (any state except IDLE).
REQ-010 Port: ready  output  1  one-cycle response strobe.
REQ-011 Port: rdata  output  32  load data; valid only while ready=1.
REQ-012 Port: err  output  1  misaligned-access flag; valid only while ready=1.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, WAIT and RESP.
REQ-014 IDLE SHALL accept the request when req=1 at a rising edge: capture we, addr and wdata; load the wait counter with LATENCY-1; go to WAIT.
REQ-015 The block SHALL ignore req in WAIT and RESP, with no capture and no queueing.
REQ-016 WAIT SHALL decrement the counter each cycle and move to RESP on the edge where the counter is 0.
REQ-017 Latency: with acceptance at edge E0, ready SHALL be high exactly during the cycle after edge E0+LATENCY, for one cycle; RESP SHALL always return to IDLE.
REQ-018 Word index SHALL be addr[log2(DEPTH)+1:2]; higher address bits SHALL be ignored, so addresses alias modulo DEPTH*4.
REQ-019 Misaligned access (captured addr[1:0] != 0) SHALL produce err=1 and rdata=0 in RESP, and SHALL NOT modify memory.
REQ-020 Aligned store SHALL write wdata to the indexed word on the WAIT->RESP edge; in RESP, rdata=0 and err=0.
REQ-021 Aligned load SHALL present the indexed word on rdata in RESP with err=0; a store and load to the same word in consecutive transactions SHALL return the new data.
REQ-022 Outside RESP, ready, err and rdata SHALL be 0.
REQ-023 busy SHALL be 1 in WAIT and RESP and 0 in IDLE; a req coincident with busy=1 SHALL be lost.
REQ-024 Minimum spacing between accepted requests SHALL be LATENCY+2 cycles; a req in the cycle after RESP SHALL be accepted.

Reset
REQ-025 When reset=1 at a rising edge: state SHALL go to IDLE; counter and captured fields SHALL clear to 0; busy, ready, err and rdata SHALL be 0 on the next cycle; all DEPTH words SHALL clear to 0.
REQ-026 Reset SHALL take priority over req in the same cycle; the request is not accepted.
REQ-027 Reset during WAIT SHALL abort the transaction: no write is committed and no ready is issued.
REQ-028 Reset during RESP SHALL suppress ready on the following cycle; a store already committed is then cleared by the memory reset.

Verification
REQ-029 Bench SHALL cover this scenario: reset, then load from 0x00000010 -> ready=1 for one cycle, 3 cycles after acceptance (LATENCY=2); rdata=0; err=0.
REQ-030 Bench SHALL cover this scenario: store 0xDEADBEEF at 0x00000008, then load from 0x00000108 (DEPTH=64, aliases) -> rdata=0xDEADBEEF.
REQ-031 Bench SHALL cover this scenario: store 0x12345678 at 0x00000006 -> err=1 in RESP; a later load from 0x00000004 returns 0.
REQ-032 Bench SHALL cover this scenario: second req pulse issued one cycle after acceptance -> ignored; exactly one ready; busy=1 through RESP; a req the cycle after RESP is accepted.
REQ-033 Bench SHALL cover this scenario: store 0xCAFEF00D to 0x00000020 with reset asserted in the first WAIT cycle -> no ready; a later load from 0x00000020 returns 0.
REQ-034 Bench SHALL cover this scenario: LATENCY=1 and LATENCY=15 builds -> ready exactly 2 and 16 cycles after acceptance respectively.

Source files
------------

// File: rtl/mem_responder.sv
// Single-port word memory behind a fixed-latency request/response handshake
// for a multicycle core: one request in flight, everything else dropped.
module mem_responder #(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned AddrW = IdxW + 2;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  localparam logic [3:0] CntInit = 4'(LATENCY - 1);

  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [AddrW-1:0] addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;
  logic [31:0]      mem_q [DEPTH];

  logic [IdxW-1:0]  idx;
  logic             misaligned;
  logic             commit;

  // Bits above the word index only alias and are intentionally dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:AddrW];

  assign idx        = addr_q[AddrW-1:2];
  assign misaligned = (addr_q[1:0] != 2'b00);
  assign commit     = (state_q == StWait) && (cnt_q == 4'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      StIdle: begin
        if (req) begin
          state_d = StWait;
          cnt_d   = CntInit;
          we_d    = we;
          addr_d  = addr[AddrW-1:0];
          wdata_d = wdata;
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Response payload is latched on the WAIT->RESP edge and only survives one cycle.
  always_comb begin
    rdata_d = 32'd0;
    err_d   = 1'b0;
    if (commit) begin
      err_d = misaligned;
      if (!we_q && !misaligned) begin
        rdata_d = mem_q[idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= 32'd0;
      end
    end else if (commit && we_q && !misaligned) begin
      mem_q[idx] <= wdata_q;
    end
  end

  assign busy  = (state_q != StIdle);
  assign ready = (state_q == StResp);
  assign rdata = rdata_q;
  assign err   = err_q;

endmodule
